// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the systolic MAC array: accepts one K-step vector per
// cycle, applies the per-lane diagonal skew and appends a zero flush per tile.
module systolic_skew_feeder #(
  parameter int M  = 256,
  parameter int N  = 256,
  parameter int K  = 256,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0][DW-1:0] in_a,
  input  logic [M-1:0][DW-1:0] in_b,
  output logic [N-1:0][DW-1:0] data_outA,
  output logic [M-1:0][DW-1:0] data_outB,
  output logic                 busy,
  output logic                 tile_done
);

  localparam int KW = $clog2(K + 1);
  localparam int FW = $clog2(M + N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [KW-1:0] K_LAST     = KW'(K);
  // fcnt runs 0..M+N-2, giving M+N-1 flush cycles per tile
  localparam logic [FW-1:0] FLUSH_LAST = FW'(M + N - 2);

  logic [1:0]    state_r, state_s;
  logic [KW-1:0] kcnt_r, kcnt_s;
  logic [FW-1:0] fcnt_r, fcnt_s;
  logic          busy_r, tile_done_r;
  logic          accept_s;

  logic [N-1:0][DW-1:0] head_a_s;
  logic [M-1:0][DW-1:0] head_b_s;

  assign in_ready  = (state_r == S_IDLE) || (state_r == S_FEED);
  assign accept_s  = in_valid && in_ready;
  assign busy      = busy_r;
  assign tile_done = tile_done_r;

  // A cycle without an accept pushes an all-zero step so lane alignment holds
  assign head_a_s = accept_s ? in_a : '0;
  assign head_b_s = accept_s ? in_b : '0;

  // Next-state logic for the tile sequencer
  always_comb begin
    state_s = state_r;
    kcnt_s  = kcnt_r;
    fcnt_s  = fcnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          kcnt_s = KW'(1);
          fcnt_s = '0;
          if (K == 1) begin
            state_s = S_FLUSH;
          end else begin
            state_s = S_FEED;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FEED: begin
        if (accept_s) begin
          kcnt_s = kcnt_r + KW'(1);
          if ((kcnt_r + KW'(1)) == K_LAST) begin
            state_s = S_FLUSH;
            fcnt_s  = '0;
          end else begin
            state_s = S_FEED;
          end
        end else begin
          state_s = S_FEED;
        end
      end
      S_FLUSH: begin
        if (fcnt_r == FLUSH_LAST) begin
          state_s = S_IDLE;
          kcnt_s  = '0;
          fcnt_s  = '0;
        end else begin
          fcnt_s = fcnt_r + FW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        kcnt_s  = '0;
        fcnt_s  = '0;
      end
    endcase
  end

  // Sequencer state plus registered busy / tile_done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      kcnt_r      <= '0;
      fcnt_r      <= '0;
      busy_r      <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      kcnt_r      <= kcnt_s;
      fcnt_r      <= fcnt_s;
      busy_r      <= (state_s == S_FEED) || (state_s == S_FLUSH);
      tile_done_r <= (state_s == S_FLUSH) && (fcnt_s == FLUSH_LAST);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane_a
      logic [DW-1:0] sh_r [0:gi];

      // Lane gi of A: gi+1 stage shift chain, free-running
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k <= gi; k++) begin
            sh_r[k] <= '0;
          end
        end else begin
          sh_r[0] <= head_a_s[gi];
          for (int k = 1; k <= gi; k++) begin
            sh_r[k] <= sh_r[k-1];
          end
        end
      end

      assign data_outA[gi] = sh_r[gi];
    end

    for (gi = 0; gi < M; gi++) begin : g_lane_b
      logic [DW-1:0] sh_r [0:gi];

      // Lane gi of B: gi+1 stage shift chain, free-running
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k <= gi; k++) begin
            sh_r[k] <= '0;
          end
        end else begin
          sh_r[0] <= head_b_s[gi];
          for (int k = 1; k <= gi; k++) begin
            sh_r[k] <= sh_r[k-1];
          end
        end
      end

      assign data_outB[gi] = sh_r[gi];
    end
  endgenerate

endmodule
